// File: rtl/prime_game_pkg.sv
// Shared definitions for the prime-game round sequencer.
//   state_t           : round sequencer FSM states (also exposed for debug)
//   eng_state_t       : trial-division engine FSM states
//   SHOW_CYCLES_DEF   : default number of cycles a result is displayed
//   SMALL_PRIME_MASK  : bit n set when n (0..15) is prime
package prime_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_NUM,
    ST_WAIT_GUESS,
    ST_CHECK,
    ST_JUDGE,
    ST_SHOW
  } state_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_BOUND,
    ENG_DIV
  } eng_state_t;

  localparam int SHOW_CYCLES_DEF = 16;

  // Primes below 16: 2, 3, 5, 7, 11, 13.
  localparam logic [15:0] SMALL_PRIME_MASK = 16'h28AC;

endpackage

// File: rtl/prime_round_sequencer_if.sv
// Bus between the game-control / RNG / player-input side (master) and the
// round sequencer (slave).
// Handshake: there is no valid/ready pair. load_num, load_guess, timeout and
// clear_score are single-cycle pulses the slave samples on the rising clock
// edge; game_active is a level. result_valid is high for the whole display
// window and the result_* / score / rounds fields are stable while it is high.
// state_dbg exposes the sequencer FSM state for observation.
interface prime_round_sequencer_if #(
  parameter int W       = 8,
  parameter int SCORE_W = 8
);
  logic                       game_active;
  logic                       load_num;
  logic [W-1:0]               rng_value;
  logic                       load_guess;
  logic                       guess_prime;
  logic                       timeout;
  logic                       clear_score;
  logic [W-1:0]               num_latched;
  logic                       busy;
  logic                       result_valid;
  logic                       result_correct;
  logic                       result_prime;
  logic [SCORE_W-1:0]         score;
  logic [SCORE_W-1:0]         rounds;
  prime_game_pkg::state_t     state_dbg;

  modport master (
    output game_active, load_num, rng_value, load_guess, guess_prime,
           timeout, clear_score,
    input  num_latched, busy, result_valid, result_correct, result_prime,
           score, rounds, state_dbg
  );

  modport slave (
    input  game_active, load_num, rng_value, load_guess, guess_prime,
           timeout, clear_score,
    output num_latched, busy, result_valid, result_correct, result_prime,
           score, rounds, state_dbg
  );
endinterface

// File: rtl/prime_div_engine.sv
// Iterative trial-division primality engine.
//   start    : pulse, latch n and begin (ignored while busy)
//   abort    : return to idle next cycle
//   n        : number under test
//   done     : one-cycle pulse when the verdict is ready
//   is_prime : verdict, held until the next verdict
//   busy     : engine is not idle
// Divisors d = 2, 3, ... are tried while d*d <= n. Each n mod d is a restoring
// shift-subtract over the W bits of n (W cycles), preceded by one bound cycle.
module prime_div_engine
  import prime_game_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] n,
  output logic         done,
  output logic         is_prime,
  output logic         busy
);
  localparam int DW = W / 2 + 1;
  localparam int SW = W + 2;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  eng_state_t    st, st_n;
  logic [W-1:0]  n_q;
  logic [W-1:0]  shreg;
  logic [DW-1:0] d;
  logic [DW-1:0] rem;     // always < d after each restoring step
  logic [DW:0]   rem_sh;
  logic [DW:0]   rem_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] d_sq;
  logic          bound_hit;
  logic          last_bit;

  assign d_sq      = SW'(d) * SW'(d);
  assign bound_hit = d_sq > SW'(n_q);
  assign last_bit  = (cnt == CW'(W - 1));
  assign rem_sh    = {rem, shreg[W-1]};
  assign rem_nx    = (rem_sh >= {1'b0, d}) ? (rem_sh - {1'b0, d}) : rem_sh;
  assign busy      = (st != ENG_IDLE);

  always_comb begin
    st_n = st;
    unique case (st)
      ENG_IDLE:  if (start) st_n = ENG_BOUND;
      ENG_BOUND: st_n = bound_hit ? ENG_IDLE : ENG_DIV;
      ENG_DIV:   if (last_bit) st_n = (rem_nx == '0) ? ENG_IDLE : ENG_BOUND;
      default:   st_n = ENG_IDLE;
    endcase
    if (abort) st_n = ENG_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= ENG_IDLE;
      n_q      <= '0;
      shreg    <= '0;
      d        <= '0;
      rem      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      is_prime <= 1'b0;
    end else begin
      st   <= st_n;
      done <= 1'b0;
      if (!abort) begin
        case (st)
          ENG_IDLE: begin
            if (start) begin
              n_q <= n;
              d   <= DW'(2);
            end
          end
          ENG_BOUND: begin
            if (bound_hit) begin
              // No divisor found up to sqrt(n); 0 and 1 are not prime.
              done     <= 1'b1;
              is_prime <= (n_q >= W'(2));
            end else begin
              shreg <= n_q;
              rem   <= '0;
              cnt   <= '0;
            end
          end
          ENG_DIV: begin
            shreg <= shreg << 1;
            rem   <= rem_nx[DW-1:0];
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
              if (rem_nx == '0) begin
                done     <= 1'b1;
                is_prime <= 1'b0;
              end else begin
                d <= d + DW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/prime_round_sequencer.sv
// Sequences one round of the prime game: latch the RNG value, wait for the
// player's guess, run the trial-division engine, judge and keep score, then
// display the result for SHOW_CYCLES cycles.
//   clk, rst : clock, synchronous active-low reset
//   bus      : game/RNG/player inputs and result/score outputs (slave side)
// game_active low aborts any round; clear_score zeroes score and rounds and
// wins over a same-cycle increment.
module prime_round_sequencer
  import prime_game_pkg::*;
#(
  parameter int W           = 8,
  parameter int SCORE_W     = 8,
  parameter int SHOW_CYCLES = SHOW_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  prime_round_sequencer_if.slave bus
);
  localparam int SCW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES + 1) : 1;

  state_t             state, state_n;
  logic               abort;
  logic               eng_start, eng_done, eng_is_prime, eng_busy;
  logic               guess_q;
  logic               correct_now;
  logic [W-1:0]       num_q;
  logic               res_correct_q, res_prime_q;
  logic [SCORE_W-1:0] score_q, rounds_q;
  logic [SCW-1:0]     show_cnt;

  assign abort       = !bus.game_active && (state != ST_IDLE);
  assign correct_now = (guess_q == res_prime_q);

  always_comb begin
    state_n   = state;
    eng_start = 1'b0;
    unique case (state)
      ST_IDLE:       if (bus.game_active) state_n = ST_WAIT_NUM;
      ST_WAIT_NUM: begin
        if (bus.timeout)       state_n = ST_SHOW;
        else if (bus.load_num) state_n = ST_WAIT_GUESS;
      end
      ST_WAIT_GUESS: begin
        if (bus.timeout) begin
          state_n = ST_SHOW;
        end else if (bus.load_guess && !eng_busy) begin
          eng_start = 1'b1;
          state_n   = ST_CHECK;
        end
      end
      ST_CHECK:      if (eng_done) state_n = ST_JUDGE;
      ST_JUDGE:      state_n = ST_SHOW;
      ST_SHOW:       if (show_cnt == SCW'(SHOW_CYCLES - 1)) state_n = ST_WAIT_NUM;
      default:       state_n = ST_IDLE;
    endcase
    if (abort) begin
      state_n   = ST_IDLE;
      eng_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      num_q         <= '0;
      guess_q       <= 1'b0;
      res_correct_q <= 1'b0;
      res_prime_q   <= 1'b0;
      score_q       <= '0;
      rounds_q      <= '0;
      show_cnt      <= '0;
    end else begin
      state <= state_n;
      if (abort) begin
        res_correct_q <= 1'b0;
        res_prime_q   <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_NUM, ST_WAIT_GUESS: begin
            if (bus.timeout) begin
              // Forced miss: counts as a round, never as a correct one.
              res_correct_q <= 1'b0;
              res_prime_q   <= 1'b0;
              rounds_q      <= rounds_q + SCORE_W'(1);
              show_cnt      <= '0;
            end else if (state == ST_WAIT_NUM && bus.load_num) begin
              num_q <= bus.rng_value;
            end else if (state == ST_WAIT_GUESS && bus.load_guess) begin
              guess_q <= bus.guess_prime;
            end
          end
          ST_CHECK: if (eng_done) res_prime_q <= eng_is_prime;
          ST_JUDGE: begin
            res_correct_q <= correct_now;
            if (correct_now && score_q != '1) score_q <= score_q + SCORE_W'(1);
            rounds_q <= rounds_q + SCORE_W'(1);
            show_cnt <= '0;
          end
          ST_SHOW:  show_cnt <= show_cnt + SCW'(1);
          default: ;
        endcase
      end
      if (bus.clear_score) begin
        score_q  <= '0;
        rounds_q <= '0;
      end
    end
  end

  prime_div_engine #(.W(W)) u_eng (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .abort    (abort),
    .n        (num_q),
    .done     (eng_done),
    .is_prime (eng_is_prime),
    .busy     (eng_busy)
  );

  assign bus.num_latched    = num_q;
  assign bus.busy           = (state == ST_CHECK) || (state == ST_JUDGE);
  assign bus.result_valid   = (state == ST_SHOW);
  assign bus.result_correct = res_correct_q;
  assign bus.result_prime   = res_prime_q;
  assign bus.score          = score_q;
  assign bus.rounds         = rounds_q;
  assign bus.state_dbg      = state;
endmodule

// File: tb/tb_prime_round_sequencer.sv
// Bench for prime_round_sequencer: directed rounds, expected results queued
// at stimulus time and checked by a monitor when result_valid rises.
module tb_prime_round_sequencer;
  import prime_game_pkg::*;

  localparam int W        = 8;
  localparam int SCORE_W  = 8;
  localparam int SHOW_C   = 16;
  localparam int LAT_MAX  = (2 ** (W / 2)) * (W + 2) + 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // {result_prime, result_correct, score, rounds}
  logic [2*SCORE_W+1:0] exp_q[$];
  logic [SCORE_W-1:0]   m_score  = '0;
  logic [SCORE_W-1:0]   m_rounds = '0;
  logic [15:0]          pmask;

  prime_round_sequencer_if #(.W(W), .SCORE_W(SCORE_W)) bus ();

  prime_round_sequencer #(.W(W), .SCORE_W(SCORE_W), .SHOW_CYCLES(SHOW_C)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // driver tasks (called at posedge+1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t s, input int budget);
    int n = 0;
    while (bus.state_dbg != s && n < budget) begin
      step();
      n++;
    end
    check($sformatf("wait_%s", s.name()), 32'(bus.state_dbg), 32'(s));
  endtask

  task automatic pulse_num(input logic [W-1:0] v);
    bus.rng_value = v;
    bus.load_num  = 1'b1;
    step();
    bus.load_num  = 1'b0;
  endtask

  task automatic pulse_guess(input logic g);
    bus.guess_prime = g;
    bus.load_guess  = 1'b1;
    step();
    bus.load_guess  = 1'b0;
  endtask

  task automatic pulse_timeout();
    bus.timeout = 1'b1;
    step();
    bus.timeout = 1'b0;
  endtask

  task automatic expect_round(input logic p, input logic c);
    if (c && m_score != '1) m_score = m_score + 1'b1;
    m_rounds = m_rounds + 1'b1;
    exp_q.push_back({p, c, m_score, m_rounds});
  endtask

  task automatic play(input logic [W-1:0] n, input logic g, input logic p);
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    pulse_num(n);
    pulse_guess(g);
    expect_round(p, g == p);
    wait_state(ST_SHOW, LAT_MAX + 4);
  endtask

  // scoreboard monitor
  logic prev_valid = 1'b0;
  int   vcnt       = 0;
  always @(negedge clk) begin
    logic [2*SCORE_W+1:0] got, exp;
    if (bus.result_valid === 1'b1 && !prev_valid) begin
      got = {bus.result_prime, bus.result_correct, bus.score, bus.rounds};
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("result", 32'(got), 32'(exp));
      end
      vcnt = 1;
    end else if (bus.result_valid === 1'b1) begin
      vcnt++;
    end else if (prev_valid) begin
      check("show_len", 32'(vcnt), 32'(SHOW_C));
    end
    prev_valid = (bus.result_valid === 1'b1);
  end

  initial begin
    pmask           = SMALL_PRIME_MASK;
    rst             = 1'b0;
    bus.game_active = 1'b0;
    bus.load_num    = 1'b0;
    bus.rng_value   = '0;
    bus.load_guess  = 1'b0;
    bus.guess_prime = 1'b0;
    bus.timeout     = 1'b0;
    bus.clear_score = 1'b0;
    repeat (3) step();
    check("reset_outputs",
          32'({bus.num_latched, bus.busy, bus.result_valid, bus.result_correct,
               bus.result_prime, bus.score, bus.rounds}), 32'h0);
    check("reset_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    step();
    bus.game_active = 1'b1;

    // prime guessed correctly, composite guessed wrongly
    play(8'd7, 1'b1, pmask[7]);
    play(8'd9, 1'b1, pmask[9]);

    // edge values, guess 0
    play(8'd0,   1'b0, pmask[0]);
    play(8'd1,   1'b0, pmask[1]);
    play(8'd2,   1'b0, pmask[2]);
    play(8'd255, 1'b0, 1'b0);
    play(8'd251, 1'b1, 1'b1);

    // timeout in WAIT_GUESS: forced miss, engine never started
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    pulse_num(8'd5);
    pulse_timeout();
    expect_round(1'b0, 1'b0);
    check("to_guess_state", 32'(bus.state_dbg), 32'(ST_SHOW));
    check("to_guess_eng_busy", 32'(u_dut.u_eng.busy), 32'h0);
    check("to_guess_busy", 32'(bus.busy), 32'h0);

    // timeout during CHECK: ignored
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    pulse_num(8'd13);
    pulse_guess(1'b1);
    expect_round(1'b1, 1'b1);
    step();
    step();
    check("to_check_busy", 32'(bus.busy), 32'h1);
    pulse_timeout();
    wait_state(ST_SHOW, LAT_MAX + 4);

    // abort mid-CHECK
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    pulse_num(8'd251);
    pulse_guess(1'b1);
    repeat (5) step();
    bus.game_active = 1'b0;
    step();
    check("abort_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check("abort_flags",
          32'({bus.result_valid, bus.result_correct, bus.result_prime, bus.busy}), 32'h0);
    check("abort_score", 32'({bus.score, bus.rounds}), 32'({m_score, m_rounds}));
    step();
    check("abort_eng_idle", 32'(u_dut.u_eng.busy), 32'h0);
    bus.game_active = 1'b1;

    // clear_score coincident with JUDGE
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    pulse_num(8'd4);
    pulse_guess(1'b0);
    wait_state(ST_JUDGE, LAT_MAX + 4);
    bus.clear_score = 1'b1;
    step();
    bus.clear_score = 1'b0;
    m_score  = '0;
    m_rounds = '0;
    exp_q.push_back({1'b0, 1'b1, m_score, m_rounds});

    // saturation: 255 correct rounds, then one more
    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    for (int i = 0; i < 255; i++) play(8'd4, 1'b0, 1'b0);
    check("sat_pre", 32'({m_score, m_rounds}), 32'h0000_FFFF);
    play(8'd4, 1'b0, 1'b0);

    wait_state(ST_WAIT_NUM, 4 * SHOW_C);
    step();
    check("sat_final", 32'({bus.score, bus.rounds}), 32'h0000_FF00);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
